rs_wakeup_select: RTL and testbench
===================================

// Module: rs_wakeup_select
// PURPOSE
//   Parametrised wakeup + select array for one functional-unit reservation station.
//   - Holds dispatched ops with per-entry producer-dependency vectors.
//   - Clears dependency bits from a global completion broadcast.
//   - Issues up to ISSUE_W ready entries per cycle, oldest first (age matrix).
//   - Sits between rename/dispatch and the FU issue ports; succeeds the single-grant wakeup.
// PARAMETERS
//   ENTRIES  8                   entries in this station
//   NUM_FUS  4                   stations in the core; producer space = ENTRIES*NUM_FUS
//   ISSUE_W  2                   max grants per cycle (1..ENTRIES)
//   SRC_W    ENTRIES*NUM_FUS     dependency/wakeup vector width (derived)
//   IDX_W    $clog2(ENTRIES)     entry index width (derived)
// PORTS
//   clk              in   1                clock, rising edge
//   rst              in   1                asynchronous, active-low reset
//   flush            in   1                sync clear of all entries
//   disp_valid       in   1                dispatch request
//   dependency_mask  in   SRC_W            producers the op waits on
//   free_entry_out   out  IDX_W            entry the next dispatch writes
//   full_out         out  1                no free entry; dispatch ignored
//   wakeup_mask      in   SRC_W            producers completing this cycle
//   fu_stall         in   ISSUE_W          per-port stall; stalled port gets no grant
//   reqs             out  ENTRIES          entry requesting issue
//   grant            out  ISSUE_W*ENTRIES  one-hot grant per port, port p = bits [p*ENTRIES+:ENTRIES]
//   grant_valid      out  ISSUE_W          port p granted this cycle
//   retire_valid     in   1                free an issued entry
//   retire_entry     in   IDX_W            entry to free
//   occupancy        out  IDX_W+1          count of valid entries
// BEHAVIOUR
//   Reset (rst=0, async)
//     - All entries FREE; age matrix cleared; dependency vectors 0.
//     - Outputs: reqs=0, grant=0, grant_valid=0, full_out=0, free_entry_out=0, occupancy=0.
//   Entry states
//     - FREE -> WAIT     on dispatch.
//     - WAIT -> ISSUED   on grant; a WAIT entry requests once its dependency vector is 0.
//     - ISSUED -> FREE   on retire of that entry.
//     - any -> FREE      on flush.
//   Dispatch
//     - free_entry_out = lowest-index FREE entry, from registered state.
//     - Accepted when disp_valid & ~full_out & ~flush.
//     - Stored dependency = dependency_mask & ~wakeup_mask (same-cycle bypass).
//   Wakeup
//     - Every edge: dep[i] &= ~wakeup_mask for all valid entries.
//     - A wakeup in cycle N gives a req in cycle N+1.
//     - A dispatch with all dependencies satisfied at edge N also requests in N+1.
//   Request
//     - reqs[i] = WAIT & (dep[i]==0); comes from registered state, so no combinational path from the wakeup input.
//   Select (combinational, same cycle as reqs)
//     - Each non-stalled port in increasing order takes the oldest remaining requester.
//     - Oldest requester i: no other remaining requester j has age[j][i]=1.
//     - Grants are unique across ports.
//     - grant_valid[p]=0 and grant slice p=0 when port p is stalled or no requester remains.
//     - Stalled ports are skipped; the remaining ports still grant.
//     - Granted entries become ISSUED at the edge.
//   Age matrix
//     - age[j][i]=1 means j is older than i.
//     - On dispatch into k: age[j][k]=1 for every valid j; age[k][*]=0.
//   Retire
//     - Frees the entry at the edge.
//     - Retire of a non-ISSUED entry is ignored.
//     - A freed entry becomes allocatable next cycle, never in the same cycle.
//   Simultaneous events
//     - Dispatch + retire: legal; the freed slot is not reused that edge.
//     - Flush beats dispatch, grant and retire; grants are still driven combinationally in the flush cycle, but their entries are cleared.
//   Occupancy and full
//     - occupancy = count of non-FREE entries.
//     - full_out = (occupancy==ENTRIES).
// TESTING
//   - Reset mid-run with 5 valid entries: all outputs return to 0 immediately, before the next clock edge; occupancy=0.
//   - Dispatch A (dep=0) then B (dep=0) -> cycle after B: reqs=0b11; port0 grants A (oldest), port1 grants B.
//   - Dispatch C with dep bit 9, then wakeup_mask bit 9 -> reqs[C]=1 exactly one cycle after the wakeup; same-cycle bypass dispatch gives req next cycle.
//   - Fill all 8 entries -> full_out=1 and a 9th dispatch is ignored; retire entry 3 -> full_out=0 next cycle, free_entry_out=3.
//   - fu_stall=0b01 with 2 ready entries -> only port1 grants, and it grants the oldest; unstalled next cycle, port0 grants the other entry.
//   - Flush asserted together with disp_valid and retire_valid -> all entries FREE, occupancy=0, no entry allocated.

Source files
------------

// File: rtl/rs_wakeup_select.sv
// Reservation-station wakeup and select array: tracks per-entry producer dependencies,
// clears them from the completion broadcast, and grants up to ISSUE_W ready entries oldest-first.
module rs_wakeup_select #(
   parameter int ENTRIES = 8,
   parameter int NUM_FUS = 4,
   parameter int ISSUE_W = 2,
   parameter int SRC_W   = ENTRIES * NUM_FUS,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         disp_valid,
   input  logic [SRC_W-1:0]             dependency_mask,
   output logic [IDX_W-1:0]             free_entry_out,
   output logic                         full_out,
   input  logic [SRC_W-1:0]             wakeup_mask,
   input  logic [ISSUE_W-1:0]           fu_stall,
   output logic [ENTRIES-1:0]           reqs,
   output logic [ISSUE_W*ENTRIES-1:0]   grant,
   output logic [ISSUE_W-1:0]           grant_valid,
   input  logic                         retire_valid,
   input  logic [IDX_W-1:0]             retire_entry,
   output logic [IDX_W:0]               occupancy
);

   // Handshake: a dispatch is taken on the edge where disp_valid=1, full_out=0 and flush=0;
   // grant slice p is meaningful only while grant_valid[p]=1, and the entry issues on that edge.

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ISSUED = 2'd2
   } entry_state_t;

   entry_state_t        r_state [ENTRIES];
   logic [SRC_W-1:0]    r_dep   [ENTRIES];
   logic [ENTRIES-1:0]  r_age   [ENTRIES];   // r_age[j][i]=1: entry j is older than entry i

   logic [ENTRIES-1:0]  w_valid;
   logic [ENTRIES-1:0]  w_issue;
   logic [ENTRIES-1:0]  w_retire_hit;
   logic [ENTRIES-1:0]  w_disp_sel;
   logic [IDX_W-1:0]    w_free_idx;
   logic                w_free_found;
   logic [IDX_W:0]      w_occ;
   logic                w_disp_fire;

   always_comb begin
      w_valid = '0;
      reqs    = '0;
      w_occ   = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         w_valid[i] = (r_state[i] != ST_FREE);
         reqs[i]    = (r_state[i] == ST_WAIT) && (r_dep[i] == '0);
         w_occ      = w_occ + {{IDX_W{1'b0}}, w_valid[i]};
      end
   end

   always_comb begin
      w_free_idx   = '0;
      w_free_found = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (!w_valid[i] && !w_free_found) begin
            w_free_idx   = IDX_W'(i);
            w_free_found = 1'b1;
         end
      end
   end

   assign occupancy      = w_occ;
   assign full_out       = (w_occ == (IDX_W+1)'(ENTRIES));
   assign free_entry_out = w_free_idx;
   assign w_disp_fire    = disp_valid & ~full_out & ~flush;

   always_comb begin
      w_disp_sel   = '0;
      w_retire_hit = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         w_disp_sel[i]   = w_disp_fire && (w_free_idx == IDX_W'(i));
         w_retire_hit[i] = retire_valid && (retire_entry == IDX_W'(i)) &&
                           (r_state[i] == ST_ISSUED);
      end
   end

   // Ports pick in increasing order; each takes the requester no remaining requester is older than.
   always_comb begin
      logic [ENTRIES-1:0] w_remain;
      logic [ENTRIES-1:0] w_pick;
      logic               w_found;
      logic               w_blocked;
      w_remain    = reqs;
      w_pick      = '0;
      w_found     = 1'b0;
      w_blocked   = 1'b0;
      grant       = '0;
      grant_valid = '0;
      w_issue     = '0;
      for (int p = 0; p < ISSUE_W; p++) begin
         w_pick  = '0;
         w_found = 1'b0;
         if (!fu_stall[p]) begin
            for (int i = 0; i < ENTRIES; i++) begin
               w_blocked = 1'b0;
               for (int j = 0; j < ENTRIES; j++) begin
                  if ((j != i) && w_remain[j] && r_age[j][i]) w_blocked = 1'b1;
               end
               if (w_remain[i] && !w_blocked && !w_found) begin
                  w_pick[i] = 1'b1;
                  w_found   = 1'b1;
               end
            end
         end
         grant[p*ENTRIES +: ENTRIES] = w_pick;
         grant_valid[p]              = w_found;
         w_remain                    = w_remain & ~w_pick;
         w_issue                     = w_issue | w_pick;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_state[i] <= ST_FREE;
            r_dep[i]   <= '0;
            r_age[i]   <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_state[i] <= ST_FREE;
            r_dep[i]   <= '0;
            r_age[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (w_valid[i]) r_dep[i] <= r_dep[i] & ~wakeup_mask;
            if (w_issue[i]) r_state[i] <= ST_ISSUED;
            if (w_retire_hit[i]) r_state[i] <= ST_FREE;
            // The target slot is FREE in registered state, so it never collides with issue/retire.
            if (w_disp_sel[i]) begin
               r_state[i] <= ST_WAIT;
               r_dep[i]   <= dependency_mask & ~wakeup_mask;
               r_age[i]   <= '0;
               for (int j = 0; j < ENTRIES; j++) begin
                  r_age[j][i] <= w_valid[j];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_rs_wakeup_select.sv
// Bench for rs_wakeup_select: directed scenarios with literal expectations, then random traffic
// checked every cycle against a sequence-number reference model of the station.
module tb_rs_wakeup_select;

   localparam int ENTRIES = 8;
   localparam int ISSUE_W = 2;
   localparam int SRC_W   = 32;
   localparam int IDX_W   = 3;

   logic                       clk;
   logic                       rst;
   logic                       flush;
   logic                       disp_valid;
   logic [SRC_W-1:0]           dependency_mask;
   logic [IDX_W-1:0]           free_entry_out;
   logic                       full_out;
   logic [SRC_W-1:0]           wakeup_mask;
   logic [ISSUE_W-1:0]         fu_stall;
   logic [ENTRIES-1:0]         reqs;
   logic [ISSUE_W*ENTRIES-1:0] grant;
   logic [ISSUE_W-1:0]         grant_valid;
   logic                       retire_valid;
   logic [IDX_W-1:0]           retire_entry;
   logic [IDX_W:0]             occupancy;

   rs_wakeup_select dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .disp_valid      (disp_valid),
      .dependency_mask (dependency_mask),
      .free_entry_out  (free_entry_out),
      .full_out        (full_out),
      .wakeup_mask     (wakeup_mask),
      .fu_stall        (fu_stall),
      .reqs            (reqs),
      .grant           (grant),
      .grant_valid     (grant_valid),
      .retire_valid    (retire_valid),
      .retire_entry    (retire_entry),
      .occupancy       (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: 0=free, 1=waiting, 2=issued; age is a dispatch sequence number.
   int               m_st  [ENTRIES];
   logic [SRC_W-1:0] m_dep [ENTRIES];
   int               m_seq [ENTRIES];
   int               seq_ctr;

   logic [ENTRIES-1:0]         e_reqs;
   logic [ISSUE_W*ENTRIES-1:0] e_grant;
   logic [ISSUE_W-1:0]         e_gv;
   int                         e_occ;
   logic                       e_full;
   int                         e_free;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_st[i]  = 0;
         m_dep[i] = '0;
         m_seq[i] = 0;
      end
      seq_ctr = 0;
   endtask

   task automatic model_outputs();
      logic [ENTRIES-1:0] rem;
      int best;
      e_reqs  = '0;
      e_grant = '0;
      e_gv    = '0;
      e_occ   = 0;
      e_free  = -1;
      for (int i = 0; i < ENTRIES; i++) begin
         e_reqs[i] = (m_st[i] == 1) && (m_dep[i] == '0);
         if (m_st[i] != 0) e_occ++;
         else if (e_free < 0) e_free = i;
      end
      e_full = (e_occ == ENTRIES);
      rem = e_reqs;
      for (int p = 0; p < ISSUE_W; p++) begin
         if (!fu_stall[p]) begin
            best = -1;
            for (int i = 0; i < ENTRIES; i++) begin
               if (rem[i] && (best < 0 || m_seq[i] < m_seq[best])) best = i;
            end
            if (best >= 0) begin
               e_grant[p*ENTRIES + best] = 1'b1;
               e_gv[p]   = 1'b1;
               rem[best] = 1'b0;
            end
         end
      end
   endtask

   // Called just after a negedge with inputs already driven; returns at the next negedge.
   task automatic step();
      int               n_st  [ENTRIES];
      logic [SRC_W-1:0] n_dep [ENTRIES];
      int               n_seq [ENTRIES];
      #2;
      model_outputs();
      chk("reqs", 32'(reqs), 32'(e_reqs));
      chk("grant", 32'(grant), 32'(e_grant));
      chk("grant_valid", 32'(grant_valid), 32'(e_gv));
      chk("occupancy", 32'(occupancy), 32'(e_occ));
      chk("full_out", 32'(full_out), 32'(e_full));
      if (!e_full) chk("free_entry_out", 32'(free_entry_out), 32'(e_free));
      n_st  = m_st;
      n_dep = m_dep;
      n_seq = m_seq;
      if (flush) begin
         for (int i = 0; i < ENTRIES; i++) begin
            n_st[i]  = 0;
            n_dep[i] = '0;
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (m_st[i] != 0) n_dep[i] = m_dep[i] & ~wakeup_mask;
            for (int p = 0; p < ISSUE_W; p++) begin
               if (e_grant[p*ENTRIES + i]) n_st[i] = 2;
            end
         end
         if (retire_valid && m_st[retire_entry] == 2) n_st[retire_entry] = 0;
         if (disp_valid && !e_full) begin
            n_st[e_free]  = 1;
            n_dep[e_free] = dependency_mask & ~wakeup_mask;
            n_seq[e_free] = seq_ctr;
            seq_ctr++;
         end
      end
      @(posedge clk);
      m_st  = n_st;
      m_dep = n_dep;
      m_seq = n_seq;
      @(negedge clk);
   endtask

   task automatic idle(input logic [ISSUE_W-1:0] stall);
      flush           = 1'b0;
      disp_valid      = 1'b0;
      dependency_mask = '0;
      wakeup_mask     = '0;
      fu_stall        = stall;
      retire_valid    = 1'b0;
      retire_entry    = '0;
   endtask

   task automatic dispatch(input logic [SRC_W-1:0] dep, input logic [SRC_W-1:0] wk,
                           input logic [ISSUE_W-1:0] stall);
      idle(stall);
      disp_valid      = 1'b1;
      dependency_mask = dep;
      wakeup_mask     = wk;
      step();
   endtask

   task automatic retire(input int idx, input logic [ISSUE_W-1:0] stall);
      idle(stall);
      retire_valid = 1'b1;
      retire_entry = IDX_W'(idx);
      step();
   endtask

   function automatic logic [SRC_W-1:0] sparse_mask(input int max_bits, input int top);
      logic [SRC_W-1:0] m;
      m = '0;
      for (int k = 0; k < max_bits; k++) begin
         if ($urandom_range(0, 1) == 1) m[$urandom_range(0, top)] = 1'b1;
      end
      return m;
   endfunction

   initial begin
      rst = 1'b0;
      idle(2'b00);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset_reqs", 32'(reqs), 32'h0);
      chk("reset_grant", 32'(grant), 32'h0);
      chk("reset_occupancy", 32'(occupancy), 32'h0);
      chk("reset_full", 32'(full_out), 32'h0);
      chk("reset_free", 32'(free_entry_out), 32'h0);
      rst = 1'b1;
      @(negedge clk);

      // A then B with no dependencies, ports held stalled until both are in.
      dispatch('0, '0, 2'b11);
      dispatch('0, '0, 2'b11);
      idle(2'b11);
      #1;
      chk("ab_reqs", 32'(reqs), 32'h03);
      fu_stall = 2'b00;
      #1;
      chk("ab_grant", 32'(grant), 32'h0201);
      chk("ab_grant_valid", 32'(grant_valid), 32'h3);
      step();

      // C waits on producer 9; wakeup in one cycle gives a request in the next.
      dispatch(32'h0000_0200, '0, 2'b11);
      idle(2'b11);
      wakeup_mask = 32'h0000_0200;
      #1;
      chk("c_req_in_wakeup_cycle", 32'(reqs[2]), 32'h0);
      step();
      idle(2'b11);
      #1;
      chk("c_req_after_wakeup", 32'(reqs[2]), 32'h1);
      step();
      dispatch(32'h0000_0020, 32'h0000_0020, 2'b11);
      idle(2'b11);
      #1;
      chk("bypass_req", 32'(reqs[3]), 32'h1);
      step();

      // Flush together with dispatch, retire and live grants.
      idle(2'b00);
      flush           = 1'b1;
      disp_valid      = 1'b1;
      retire_valid    = 1'b1;
      retire_entry    = 3'd0;
      step();
      idle(2'b00);
      #1;
      chk("flush_occupancy", 32'(occupancy), 32'h0);
      chk("flush_reqs", 32'(reqs), 32'h0);
      chk("flush_free", 32'(free_entry_out), 32'h0);
      step();

      // Port 0 stalled: port 1 takes the oldest, port 0 takes the other next cycle.
      dispatch('0, '0, 2'b11);
      dispatch('0, '0, 2'b11);
      idle(2'b01);
      #1;
      chk("stall_gv", 32'(grant_valid), 32'h2);
      chk("stall_grant", 32'(grant), 32'h0100);
      step();
      idle(2'b00);
      #1;
      chk("unstall_gv", 32'(grant_valid), 32'h1);
      chk("unstall_grant", 32'(grant), 32'h0002);
      step();

      // Fill all entries, try a ninth, then retire entry 3.
      idle(2'b11);
      flush = 1'b1;
      step();
      for (int k = 0; k < ENTRIES; k++) dispatch('0, '0, 2'b11);
      idle(2'b11);
      #1;
      chk("full_set", 32'(full_out), 32'h1);
      dispatch('0, '0, 2'b11);
      idle(2'b11);
      #1;
      chk("full_occupancy", 32'(occupancy), 32'h8);
      idle(2'b00);
      step();
      idle(2'b00);
      step();
      retire(3, 2'b11);
      idle(2'b11);
      #1;
      chk("retire_full", 32'(full_out), 32'h0);
      chk("retire_free", 32'(free_entry_out), 32'h3);
      retire(0, 2'b11);
      retire(1, 2'b11);

      // Asynchronous reset with five live entries, some of which would otherwise grant.
      idle(2'b00);
      #1;
      chk("pre_reset_occupancy", 32'(occupancy), 32'h5);
      rst = 1'b0;
      #1;
      chk("async_reset_occupancy", 32'(occupancy), 32'h0);
      chk("async_reset_grant", 32'(grant), 32'h0);
      chk("async_reset_gv", 32'(grant_valid), 32'h0);
      chk("async_reset_reqs", 32'(reqs), 32'h0);
      chk("async_reset_full", 32'(full_out), 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         idle(2'($urandom_range(0, 3)));
         flush           = ($urandom_range(0, 99) < 2);
         disp_valid      = ($urandom_range(0, 99) < 60);
         dependency_mask = sparse_mask(2, 11);
         if ($urandom_range(0, 9) == 0) dependency_mask = sparse_mask(3, SRC_W-1);
         wakeup_mask     = sparse_mask(3, 11);
         if ($urandom_range(0, 4) == 0) wakeup_mask = '1;
         retire_valid    = ($urandom_range(0, 99) < 50);
         retire_entry    = IDX_W'($urandom_range(0, ENTRIES-1));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
